// File: rtl/counter_sat_pkg.sv
// Shared definitions for counter_sat_n: FSM state encoding and the
// elaboration-time parameter legality check.
package counter_sat_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SAT = 1'b1
  } state_t;

  // True when 1 <= max_count <= 2^width-1 for a practical register width.
  function automatic bit params_ok(input int width, input int max_count);
    longint lim;
    if (width < 32'sd1 || width > 32'sd31) begin
      return 1'b0;
    end else begin
      lim = (64'sd1 << width) - 64'sd1;
      return (max_count >= 32'sd1) && (longint'(max_count) <= lim);
    end
  endfunction

endpackage

// File: rtl/counter_sat_n.sv
// Parametrised up/down counter with synchronous load, enable and a sticky
// saturation state. Optional wrap-around mode: define COUNTER_SAT_RECYCLE_EN.
module counter_sat_n
  import counter_sat_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 7
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`ifdef COUNTER_SAT_RECYCLE_EN
  input  logic             recycle,
`endif
  output logic [WIDTH-1:0] count,
  output logic             sat,
  output logic             done
);

  if (!params_ok(WIDTH, MAX_COUNT)) begin : g_bad_params
    $error("counter_sat_n: MAX_COUNT must lie in 1..2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(32'd1);
  localparam logic [WIDTH-1:0] ZERO    = WIDTH'(32'd0);

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;
  logic [WIDTH-1:0] limit_s;
  logic [WIDTH-1:0] clamped_s;
  logic [WIDTH-1:0] step_s;
  logic             wrap_s;
  logic             sat_r;
  logic             done_r;
  logic             done_next_s;

  // Next-state, next-count and done decision; load outranks enable.
  always_comb begin
    limit_s      = down ? ZERO : MAX_VAL;
    clamped_s    = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    step_s       = down ? (count_r - ONE) : (count_r + ONE);
`ifdef COUNTER_SAT_RECYCLE_EN
    wrap_s       = recycle;
`else
    wrap_s       = 1'b0;
`endif
    count_next_s = count_r;
    state_next_s = state_r;
    done_next_s  = 1'b0;

    if (load) begin
      count_next_s = clamped_s;
      state_next_s = (clamped_s == limit_s) ? SAT : RUN;
    end else if (enable && (state_r == RUN)) begin
      if (wrap_s) begin
        // Recycling never saturates; reaching the limit is just another step.
        if (count_r == limit_s) begin
          count_next_s = down ? MAX_VAL : ZERO;
          done_next_s  = 1'b1;
        end else begin
          count_next_s = step_s;
        end
      end else if (count_r == limit_s) begin
        // Already at the limit (e.g. reset with down=1): saturate in place.
        state_next_s = SAT;
        done_next_s  = 1'b1;
      end else begin
        count_next_s = step_s;
        if (step_s == limit_s) begin
          state_next_s = SAT;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_r <= ZERO;
      state_r <= RUN;
      sat_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      state_r <= state_next_s;
      sat_r   <= (state_next_s == SAT);
      done_r  <= done_next_s;
    end
  end

  assign count = count_r;
  assign sat   = sat_r;
  assign done  = done_r;

endmodule

// File: tb/tb_counter_sat_n.sv
// Self-checking bench for counter_sat_n: three parameterisations driven in
// lockstep against a behavioural model, plus table and hand-written checks.
module tb_counter_sat_n;

  typedef struct packed {
    int cnt;
    bit sat;
    bit done;
  } mstate_t;

  typedef struct {
    bit en;
    bit dn;
    bit ld;
    int lv;
    int exp_cnt;
    bit exp_sat;
    bit exp_done;
  } vec_t;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       en = 1'b0, dn = 1'b0, ld = 1'b0, rc = 1'b0;
  logic [2:0] lv0 = 3'd0;
  logic [5:0] lv1 = 6'd0;
  logic [3:0] lv2 = 4'd0;
  logic [2:0] count0;
  logic [5:0] count1;
  logic [3:0] count2;
  logic       sat0, sat1, sat2, done0, done1, done2;

  int n_cmp = 0;
  int n_err = 0;
  mstate_t m0, m1, m2;

  always #5 clock = ~clock;

  counter_sat_n dut0 (
    .clock(clock), .clear(clear), .enable(en), .down(dn), .load(ld),
    .load_value(lv0),
`ifdef COUNTER_SAT_RECYCLE_EN
    .recycle(rc),
`endif
    .count(count0), .sat(sat0), .done(done0));

  counter_sat_n #(.WIDTH(6), .MAX_COUNT(59)) dut1 (
    .clock(clock), .clear(clear), .enable(en), .down(dn), .load(ld),
    .load_value(lv1),
`ifdef COUNTER_SAT_RECYCLE_EN
    .recycle(rc),
`endif
    .count(count1), .sat(sat1), .done(done1));

  counter_sat_n #(.WIDTH(4), .MAX_COUNT(7)) dut2 (
    .clock(clock), .clear(clear), .enable(en), .down(dn), .load(ld),
    .load_value(lv2),
`ifdef COUNTER_SAT_RECYCLE_EN
    .recycle(rc),
`endif
    .count(count2), .sat(sat2), .done(done2));

  // Reference behaviour written straight from the counting rules.
  function automatic mstate_t model(input mstate_t s, input int max, input bit e,
                                    input bit d, input bit l, input int v, input bit r);
    mstate_t n;
    int lim;
    n = s;
    n.done = 1'b0;
    lim = d ? 0 : max;
    if (l) begin
      n.cnt = (v > max) ? max : v;
      n.sat = (n.cnt == lim);
    end else if (e && !s.sat) begin
      if (r) begin
        if (s.cnt == lim) begin
          n.cnt = d ? max : 0;
          n.done = 1'b1;
        end else begin
          n.cnt = d ? s.cnt - 1 : s.cnt + 1;
        end
      end else begin
        if (s.cnt != lim) n.cnt = d ? s.cnt - 1 : s.cnt + 1;
        if (n.cnt == lim) begin
          n.sat = 1'b1;
          n.done = 1'b1;
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    check("d0_count", 32'(count0), m0.cnt); check("d0_sat", 32'(sat0), 32'(m0.sat));
    check("d0_done", 32'(done0), 32'(m0.done));
    check("d1_count", 32'(count1), m1.cnt); check("d1_sat", 32'(sat1), 32'(m1.sat));
    check("d1_done", 32'(done1), 32'(m1.done));
    check("d2_count", 32'(count2), m2.cnt); check("d2_sat", 32'(sat2), 32'(m2.sat));
    check("d2_done", 32'(done2), 32'(m2.done));
  endtask

  task automatic step(input bit e, input bit d, input bit l, input int v);
    en = e; dn = d; ld = l;
    lv0 = 3'(v); lv1 = 6'(v); lv2 = 4'(v);
    @(posedge clock);
    #1;
    m0 = model(m0, 7, e, d, l, int'(lv0), rc);
    m1 = model(m1, 59, e, d, l, int'(lv1), rc);
    m2 = model(m2, 7, e, d, l, int'(lv2), rc);
    check_models();
  endtask

  // Asynchronous clear pulled low between edges; outputs must drop at once.
  task automatic do_reset(input string name);
    #3 clear = 1'b0;
    #1;
    check({name, "_count0"}, 32'(count0), 32'd0);
    check({name, "_count1"}, 32'(count1), 32'd0);
    check({name, "_sat"}, 32'({sat0, sat1, sat2}), 32'd0);
    check({name, "_done"}, 32'({done0, done1, done2}), 32'd0);
    m0 = '0; m1 = '0; m2 = '0;
    #1 clear = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    #11;
    do_reset("reset");

    // At the down limit in RUN after reset: first enable saturates and pulses done.
    step(1'b1, 1'b1, 1'b0, 0);
    check("rst_dn_count", 32'(count0), 32'd0); check("rst_dn_sat", 32'(sat0), 32'd1);
    check("rst_dn_done", 32'(done0), 32'd1);
    step(1'b1, 1'b1, 1'b0, 0);
    check("rst_dn_done2", 32'(done0), 32'd0);
    do_reset("reset2");

    for (int i = 0; i < 10; i++)
      tbl.push_back('{1, 0, 0, 0, (i < 7) ? i + 1 : 7, i >= 6, i == 6});
    tbl.push_back('{0, 0, 1, 3, 3, 0, 0});
    tbl.push_back('{0, 0, 1, 5, 5, 0, 0});
    tbl.push_back('{1, 0, 1, 2, 2, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 7, 7, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 7, 1, 1});
    tbl.push_back('{0, 0, 1, 4, 4, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 4, 0, 0});
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].dn, tbl[i].ld, tbl[i].lv);
      check($sformatf("tbl%0d_count", i), 32'(count0), 32'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_sat", i), 32'(sat0), 32'(tbl[i].exp_sat));
      check($sformatf("tbl%0d_done", i), 32'(done0), 32'(tbl[i].exp_done));
    end

    // WIDTH=6, MAX_COUNT=59: count down from 5 to 0, then hold.
    step(1'b0, 1'b1, 1'b1, 5);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 1'b0, 0);
      check($sformatf("w6_dn%0d_count", i), 32'(count1), (i < 5) ? 32'(4 - i) : 32'd0);
      check($sformatf("w6_dn%0d_sat", i), 32'(sat1), 32'(i >= 4));
      check($sformatf("w6_dn%0d_done", i), 32'(done1), 32'(i == 4));
    end

    // Clamp while saturated at 7, then reload a mid value to resume.
    step(1'b0, 1'b0, 1'b1, 7);
    check("clamp_pre_sat", 32'(sat2), 32'd1);
    step(1'b1, 1'b0, 1'b1, 9);
    check("clamp_count", 32'(count2), 32'd7); check("clamp_sat", 32'(sat2), 32'd1);
    check("clamp_done", 32'(done2), 32'd0);
    step(1'b0, 1'b0, 1'b1, 3);
    check("reload_count", 32'(count2), 32'd3); check("reload_sat", 32'(sat2), 32'd0);

    step(1'b0, 1'b0, 1'b1, 4);
    check("mid_count", 32'(count0), 32'd4);
    do_reset("async");

`ifdef COUNTER_SAT_RECYCLE_EN
    rc = 1'b1;
    step(1'b0, 1'b0, 1'b1, 6);
    step(1'b1, 1'b0, 1'b0, 0);
    check("rc_count7", 32'(count0), 32'd7); check("rc_sat7", 32'(sat0), 32'd0);
    check("rc_done7", 32'(done0), 32'd0);
    step(1'b1, 1'b0, 1'b0, 0);
    check("rc_wrap_count", 32'(count0), 32'd0); check("rc_wrap_sat", 32'(sat0), 32'd0);
    check("rc_wrap_done", 32'(done0), 32'd1);
    rc = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 63)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
